// File: rtl/autoconfig_zii_host.sv
// -----------------------------------------------------------------------------
// autoconfig_zii_host
//
// Zorro II AutoConfig initiator (host side), clocked on C7M. On START it walks
// the configuration chain at $E80000. For each board it:
//   - reads er_Type ($00/$02),
//   - reads the product ($04/$06) and manufacturer ($10..$16) nibbles,
//   - allocates a base in memory or I/O space,
//   - then either writes the base ($4A low nibble, then $48 high nibble) or
//     shuts the board up ($4C).
//
// Ports
//   C7M, RESET_n         bus clock (rising edge) / async active-low reset
//   START                1-cycle pulse, starts a scan when idle
//   CFG_OUT_n            CFGIN_n of the first card; held low from START until reset
//   A_HIGH, A_LOW        A23:16 and A6:1 of the current access
//   AS_n, DS_n, RW_n     bus strobes and direction
//   D_OUT, D_OE, D_IN    D15:12 write data / drive enable / sampled read data
//   BUSY, DONE           scan in progress / scan finished (until next START)
//   BOARD_CNT            boards handled in the last scan
//   REC_*                per-board record, valid while REC_VALID pulses
// -----------------------------------------------------------------------------
module autoconfig_zii_host #(
    parameter logic [7:0] MEM_START  = 8'h20,
    parameter logic [7:0] MEM_END    = 8'hA0,
    parameter logic [7:0] IO_START   = 8'hE9,
    parameter logic [7:0] IO_END     = 8'hF0,
    parameter int         MAX_BOARDS = 4
) (
    input  logic        C7M,
    input  logic        RESET_n,
    input  logic        START,
    output logic        CFG_OUT_n,
    output logic [7:0]  A_HIGH,
    output logic [5:0]  A_LOW,
    output logic        AS_n,
    output logic        DS_n,
    output logic        RW_n,
    output logic [3:0]  D_OUT,
    output logic        D_OE,
    input  logic [3:0]  D_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic [2:0]  BOARD_CNT,
    output logic        REC_VALID,
    output logic [15:0] REC_MFG,
    output logic [7:0]  REC_PROD,
    output logic [7:0]  REC_BASE,
    output logic [2:0]  REC_SIZE,
    output logic        REC_SHUTUP
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_T0, S_RD_T1, S_RD_P0, S_RD_P1,
        S_RD_M0, S_RD_M1, S_RD_M2, S_RD_M3,
        S_ALLOC, S_WR_LO, S_WR_HI, S_WR_SHUT, S_REC, S_FINISH
    } state_t;

    localparam logic [2:0] LAST_PHASE = 3'd4;
    localparam logic [2:0] MAX_CNT    = 3'(MAX_BOARDS);

    state_t      state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic        cfg_q, cfg_d;
    logic        done_q, done_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  mem_ptr_q, mem_ptr_d;
    logic [7:0]  io_ptr_q, io_ptr_d;
    logic [3:0]  type0_q, type0_d;
    logic [2:0]  size_q, size_d;
    logic [7:0]  prod_q, prod_d;
    logic [15:0] mfg_q, mfg_d;
    logic [7:0]  base_q, base_d;
    logic        shut_q, shut_d;

    // Allocation datapath
    logic       is_access;
    logic       is_write;
    logic       memlist;
    logic [8:0] units;
    logic [8:0] align;
    logic [8:0] ptr9;
    logic [8:0] end9;
    logic [8:0] base9;
    logic [8:0] top9;
    logic       fits;

    // Word address (A6:1) of each access state
    function automatic logic [5:0] reg_word(state_t s);
        case (s)
            S_RD_T0:   reg_word = 6'h00;
            S_RD_T1:   reg_word = 6'h01;
            S_RD_P0:   reg_word = 6'h02;
            S_RD_P1:   reg_word = 6'h03;
            S_RD_M0:   reg_word = 6'h08;
            S_RD_M1:   reg_word = 6'h09;
            S_RD_M2:   reg_word = 6'h0A;
            S_RD_M3:   reg_word = 6'h0B;
            S_WR_LO:   reg_word = 6'h25;
            S_WR_HI:   reg_word = 6'h24;
            S_WR_SHUT: reg_word = 6'h26;
            default:   reg_word = 6'h00;
        endcase
    endfunction

    assign is_access = (state_q != S_IDLE) && (state_q != S_ALLOC) &&
                       (state_q != S_REC)  && (state_q != S_FINISH);
    assign is_write  = (state_q == S_WR_LO) || (state_q == S_WR_HI) ||
                       (state_q == S_WR_SHUT);

    // er_Type bit 5 lives in bit 1 of the $00 nibble
    assign memlist = type0_q[1];

    always_comb begin
        case (size_q)
            3'd0:    units = 9'd128;
            3'd1:    units = 9'd1;
            3'd2:    units = 9'd2;
            3'd3:    units = 9'd4;
            3'd4:    units = 9'd8;
            3'd5:    units = 9'd16;
            3'd6:    units = 9'd32;
            default: units = 9'd64;
        endcase
    end

    // Alignment caps at 32 units (2 MB); all values are powers of two, so
    // rounding up is add-then-mask. Nine bits keep the carry for the fit test.
    assign align = (units > 9'd32) ? 9'd32 : units;
    assign ptr9  = {1'b0, memlist ? mem_ptr_q : io_ptr_q};
    assign end9  = {1'b0, memlist ? MEM_END : IO_END};
    assign base9 = (ptr9 + align - 9'd1) & ~(align - 9'd1);
    assign top9  = base9 + units;
    assign fits  = (top9 <= end9);

    // State register and datapath flops
    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= S_IDLE;
            phase_q   <= 3'd0;
            cfg_q     <= 1'b1;
            done_q    <= 1'b0;
            cnt_q     <= 3'd0;
            mem_ptr_q <= 8'h00;
            io_ptr_q  <= 8'h00;
            type0_q   <= 4'h0;
            size_q    <= 3'd0;
            prod_q    <= 8'h00;
            mfg_q     <= 16'h0000;
            base_q    <= 8'h00;
            shut_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cfg_q     <= cfg_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            mem_ptr_q <= mem_ptr_d;
            io_ptr_q  <= io_ptr_d;
            type0_q   <= type0_d;
            size_q    <= size_d;
            prod_q    <= prod_d;
            mfg_q     <= mfg_d;
            base_q    <= base_d;
            shut_q    <= shut_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (START) state_d = S_RD_T0;
            S_ALLOC:  state_d = fits ? S_WR_LO : S_WR_SHUT;
            S_REC:    state_d = ((cnt_q + 3'd1) == MAX_CNT) ? S_FINISH : S_RD_T0;
            S_FINISH: state_d = S_IDLE;
            default: begin
                if (phase_q == LAST_PHASE) begin
                    case (state_q)
                        // All-ones type nibble means nobody answered: end of chain
                        S_RD_T0:   state_d = (type0_q == 4'hF) ? S_FINISH : S_RD_T1;
                        S_RD_T1:   state_d = S_RD_P0;
                        S_RD_P0:   state_d = S_RD_P1;
                        S_RD_P1:   state_d = S_RD_M0;
                        S_RD_M0:   state_d = S_RD_M1;
                        S_RD_M1:   state_d = S_RD_M2;
                        S_RD_M2:   state_d = S_RD_M3;
                        S_RD_M3:   state_d = S_ALLOC;
                        S_WR_LO:   state_d = S_WR_HI;
                        default:   state_d = S_REC;
                    endcase
                end
            end
        endcase
    end

    // Datapath next values
    always_comb begin
        phase_d   = (is_access && phase_q != LAST_PHASE) ? phase_q + 3'd1 : 3'd0;
        cfg_d     = cfg_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        mem_ptr_d = mem_ptr_q;
        io_ptr_d  = io_ptr_q;
        type0_d   = type0_q;
        size_d    = size_q;
        prod_d    = prod_q;
        mfg_d     = mfg_q;
        base_d    = base_q;
        shut_d    = shut_q;

        if (state_q == S_IDLE && START) begin
            cfg_d     = 1'b0;
            done_d    = 1'b0;
            cnt_d     = 3'd0;
            mem_ptr_d = MEM_START;
            io_ptr_d  = IO_START;
        end

        // Read data is captured on the edge that ends T3
        if (phase_q == 3'd3) begin
            case (state_q)
                S_RD_T0: type0_d        = D_IN;
                S_RD_T1: size_d         = D_IN[2:0];
                S_RD_P0: prod_d[7:4]    = ~D_IN;
                S_RD_P1: prod_d[3:0]    = ~D_IN;
                S_RD_M0: mfg_d[15:12]   = ~D_IN;
                S_RD_M1: mfg_d[11:8]    = ~D_IN;
                S_RD_M2: mfg_d[7:4]     = ~D_IN;
                S_RD_M3: mfg_d[3:0]     = ~D_IN;
                default: ;
            endcase
        end

        if (state_q == S_ALLOC) begin
            if (fits) begin
                base_d = base9[7:0];
                shut_d = 1'b0;
                if (memlist) mem_ptr_d = top9[7:0];
                else         io_ptr_d  = top9[7:0];
            end else begin
                base_d = 8'h00;
                shut_d = 1'b1;
            end
        end

        if (state_q == S_REC)    cnt_d  = cnt_q + 3'd1;
        if (state_q == S_FINISH) done_d = 1'b1;
    end

    // Outputs: strobes low in T1-T3, data driven T0-T3 of a write
    always_comb begin
        A_HIGH = 8'h00;
        A_LOW  = 6'h00;
        AS_n   = 1'b1;
        DS_n   = 1'b1;
        RW_n   = 1'b1;
        D_OUT  = 4'h0;
        D_OE   = 1'b0;
        if (is_access) begin
            A_HIGH = 8'hE8;
            A_LOW  = reg_word(state_q);
            AS_n   = !(phase_q >= 3'd1 && phase_q <= 3'd3);
            DS_n   = !(phase_q >= 3'd1 && phase_q <= 3'd3);
            RW_n   = !is_write;
            D_OE   = is_write && (phase_q != LAST_PHASE);
            case (state_q)
                S_WR_LO: D_OUT = base_q[3:0];
                S_WR_HI: D_OUT = base_q[7:4];
                default: D_OUT = 4'h0;
            endcase
        end
    end

    assign CFG_OUT_n  = cfg_q;
    assign BUSY       = (state_q != S_IDLE);
    assign DONE       = done_q;
    assign BOARD_CNT  = cnt_q;
    assign REC_VALID  = (state_q == S_REC);
    assign REC_MFG    = mfg_q;
    assign REC_PROD   = prod_q;
    assign REC_BASE   = base_q;
    assign REC_SIZE   = size_q;
    assign REC_SHUTUP = shut_q;

endmodule

// File: tb/tb_autoconfig_zii_host.sv
// -----------------------------------------------------------------------------
// tb_autoconfig_zii_host
//
// Bench for autoconfig_zii_host with a behavioural chain of up to four Zorro II
// cards. Each card answers reads while its CFGIN_n is low. It latches its base
// from $4A/$48, or parks on $4C, and then hands the chain on to the next card.
// The expected records are computed from the allocation rules with plain
// integer arithmetic.
// -----------------------------------------------------------------------------
module tb_autoconfig_zii_host;
  localparam int MAXB  = 2;
  localparam int NSLOT = 4;

  logic        c7m, rst_n, start;
  logic        cfg_out_n, as_n, ds_n, rw_n, d_oe, busy, done, rec_valid, rec_shutup;
  logic [7:0]  a_high, rec_prod, rec_base;
  logic [5:0]  a_low;
  logic [3:0]  d_out, d_in;
  logic [2:0]  board_cnt, rec_size;
  logic [15:0] rec_mfg;

  int checks = 0;
  int errors = 0;

  // Card table
  int          nb;
  logic [3:0]  b_t0[NSLOT];
  logic [3:0]  b_t1[NSLOT];
  logic [7:0]  b_prod[NSLOT];
  logic [15:0] b_mfg[NSLOT];

  // Reference results
  logic [35:0] exp_q[$];
  int          exp_n;
  logic [8:0]  exp_res[NSLOT];
  bit          exp_touch[NSLOT];

  // Responder state
  int          cur, access_cnt;
  logic [5:0]  first_addr, wr_addr;
  logic [3:0]  wr_data;
  logic        prev_as, wr_pending;
  logic [3:0]  lo_nib[NSLOT];
  bit          lo_seen[NSLOT];
  logic [8:0]  res[NSLOT];
  bit          touched[NSLOT];

  autoconfig_zii_host #(.MAX_BOARDS(MAXB)) dut (
    .C7M(c7m), .RESET_n(rst_n), .START(start), .CFG_OUT_n(cfg_out_n),
    .A_HIGH(a_high), .A_LOW(a_low), .AS_n(as_n), .DS_n(ds_n), .RW_n(rw_n),
    .D_OUT(d_out), .D_OE(d_oe), .D_IN(d_in), .BUSY(busy), .DONE(done),
    .BOARD_CNT(board_cnt), .REC_VALID(rec_valid), .REC_MFG(rec_mfg),
    .REC_PROD(rec_prod), .REC_BASE(rec_base), .REC_SIZE(rec_size),
    .REC_SHUTUP(rec_shutup)
  );

  // ---------------- clock ----------------
  initial c7m = 1'b0;
  always #5 c7m = ~c7m;

  // ---------------- card chain ----------------
  always_comb begin
    d_in = 4'hF;
    if (!as_n && !ds_n && rw_n && !cfg_out_n && a_high == 8'hE8 && cur < nb) begin
      case (a_low)
        6'h00: d_in = b_t0[cur];
        6'h01: d_in = b_t1[cur];
        6'h02: d_in = ~b_prod[cur][7:4];
        6'h03: d_in = ~b_prod[cur][3:0];
        6'h08: d_in = ~b_mfg[cur][15:12];
        6'h09: d_in = ~b_mfg[cur][11:8];
        6'h0A: d_in = ~b_mfg[cur][7:4];
        6'h0B: d_in = ~b_mfg[cur][3:0];
        default: d_in = 4'hF;
      endcase
    end
  end

  always @(negedge c7m or negedge rst_n) begin
    if (!rst_n) begin
      cur = 0; access_cnt = 0; first_addr = 6'h3F; prev_as = 1'b1;
      wr_pending = 1'b0; wr_addr = 6'h00; wr_data = 4'h0;
      for (int i = 0; i < NSLOT; i++) begin
        lo_nib[i] = 4'h0; lo_seen[i] = 0; res[i] = 9'h000; touched[i] = 0;
      end
    end else begin
      if (!as_n && prev_as) begin
        if (access_cnt == 0) first_addr = a_low;
        access_cnt++;
        if (cur < nb) touched[cur] = 1;
      end
      if (!as_n && !ds_n && !rw_n && d_oe) begin
        wr_pending = 1'b1; wr_addr = a_low; wr_data = d_out;
      end
      // A card commits a write (and releases the chain) when AS_n rises
      if (as_n && !prev_as && wr_pending) begin
        wr_pending = 1'b0;
        if (cur < nb) begin
          case (wr_addr)
            6'h25: begin lo_nib[cur] = wr_data; lo_seen[cur] = 1; end
            6'h24: begin
              res[cur] = lo_seen[cur] ? {1'b0, wr_data, lo_nib[cur]} : 9'h1FE;
              cur++;
            end
            6'h26: begin res[cur] = {1'b1, 4'h0, wr_data}; cur++; end
            default: ;
          endcase
        end
      end
      prev_as = as_n;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_board(input int i, input logic [3:0] t0, input logic [3:0] t1,
                           input logic [7:0] prod, input logic [15:0] mfg);
    b_t0[i] = t0; b_t1[i] = t1; b_prod[i] = prod; b_mfg[i] = mfg;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge c7m);
    rst_n = 1'b1;
    @(negedge c7m);
  endtask

  // Allocation rules applied board by board with integer arithmetic
  task automatic build_model();
    int mem_ptr, io_ptr, units, align, base, endp, ptr, code;
    bit memlist;
    exp_q.delete();
    exp_n = 0; mem_ptr = 'h20; io_ptr = 'hE9;
    for (int i = 0; i < NSLOT; i++) begin exp_res[i] = 9'h000; exp_touch[i] = 0; end
    for (int i = 0; i < nb && exp_n < MAXB; i++) begin
      code    = int'(b_t1[i][2:0]);
      units   = (code == 0) ? 128 : (1 << (code - 1));
      align   = (units > 32) ? 32 : units;
      memlist = b_t0[i][1];
      ptr     = memlist ? mem_ptr : io_ptr;
      endp    = memlist ? 'hA0 : 'hF0;
      base    = ((ptr + align - 1) / align) * align;
      exp_touch[i] = 1;
      if (base + units <= endp) begin
        exp_res[i] = {1'b0, 8'(base)};
        if (memlist) mem_ptr = base + units;
        else         io_ptr  = base + units;
        exp_q.push_back({b_mfg[i], b_prod[i], 8'(base), b_t1[i][2:0], 1'b0});
      end else begin
        exp_res[i] = {1'b1, 8'h00};
        exp_q.push_back({b_mfg[i], b_prod[i], 8'h00, b_t1[i][2:0], 1'b1});
      end
      exp_n++;
    end
  endtask

  // Pulse START, follow the scan to DONE and compare everything seen
  task automatic run_scan(input string tag, output int cyc);
    int rec_seen;
    logic [35:0] e;
    rec_seen = 0;
    start = 1'b1;
    @(negedge c7m);
    start = 1'b0;
    chk({tag, ":busy_start"}, busy, 1);
    chk({tag, ":cfg_out_low"}, cfg_out_n, 0);
    chk({tag, ":done_clear"}, done, 0);
    cyc = 1;
    while (!done && cyc < 600) begin
      if (rec_valid) begin
        rec_seen++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({tag, ":rec"}, {rec_mfg, rec_prod, rec_base, rec_size, rec_shutup}, e);
        end
      end
      start = (cyc == 12);   // stray START while busy must be ignored
      @(negedge c7m);
      cyc++;
    end
    start = 1'b0;
    chk({tag, ":done"}, done, 1);
    chk({tag, ":busy_end"}, busy, 0);
    chk({tag, ":board_cnt"}, board_cnt, exp_n);
    chk({tag, ":rec_count"}, rec_seen, exp_n);
    chk({tag, ":first_addr"}, first_addr, 6'h00);
    for (int i = 0; i < NSLOT; i++) begin
      chk($sformatf("%s:card%0d_result", tag, i), res[i], exp_res[i]);
      chk($sformatf("%s:card%0d_touched", tag, i), touched[i], exp_touch[i]);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc, found;
    rst_n = 1'b1; start = 1'b0; nb = 0;
    for (int i = 0; i < NSLOT; i++) set_board(i, 4'hF, 4'hF, 8'h00, 16'h0000);
    #1 rst_n = 1'b0;
    @(negedge c7m);

    // Reset state
    chk("rst:strobes", {cfg_out_n, as_n, ds_n, rw_n, d_oe}, 5'b11110);
    chk("rst:addr_data", {a_high, a_low, d_out}, 18'h0);
    chk("rst:status", {busy, done, board_cnt, rec_valid}, 6'h0);
    chk("rst:rec", {rec_mfg, rec_prod, rec_base, rec_size, rec_shutup}, 36'h0);
    @(negedge c7m);
    rst_n = 1'b1;
    @(negedge c7m);

    // 1: single RAM card
    nb = 1; set_board(0, 4'hE, 4'h0, 8'h08, 16'h082C);
    pulse_reset(); build_model(); run_scan("t1", cyc);
    chk("t1:base_20", res[0], 9'h020);

    // 2: 4 MB RAM then a 64K I/O card
    nb = 2; set_board(0, 4'hE, 4'h7, 8'h11, 16'h1234); set_board(1, 4'hD, 4'h1, 8'h22, 16'h0ABC);
    pulse_reset(); build_model(); run_scan("t2", cyc);
    chk("t2:ram_base", res[0], 9'h020);
    chk("t2:io_base", res[1], 9'h0E9);

    // 3: empty bus
    nb = 0;
    pulse_reset(); build_model(); run_scan("t3", cyc);
    chk("t3:latency_ok", (cyc >= 5 && cyc <= 7), 1);
    chk("t3:one_access", access_cnt, 1);

    // 4: two 8 MB cards, second cannot fit
    nb = 2; set_board(0, 4'hE, 4'h0, 8'h01, 16'h0202); set_board(1, 4'hE, 4'h0, 8'h03, 16'h0404);
    pulse_reset(); build_model(); run_scan("t4", cyc);
    chk("t4:shut", res[1], {1'b1, 8'h00});

    // 5: reset in T2 of the $48 write, then rescan
    nb = 1; set_board(0, 4'hE, 4'h0, 8'h08, 16'h082C);
    pulse_reset(); build_model();
    start = 1'b1; @(negedge c7m); start = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      if (a_low == 6'h24 && !as_n) found = 1;
      else @(negedge c7m);
    end
    chk("t5:reach_48", found, 1);
    @(posedge c7m);
    #2 rst_n = 1'b0;
    #1;
    chk("t5:as_n", as_n, 1);
    chk("t5:ds_n", ds_n, 1);
    chk("t5:d_oe", d_oe, 0);
    chk("t5:cfg_out_n", cfg_out_n, 1);
    chk("t5:busy", busy, 0);
    @(negedge c7m); rst_n = 1'b1; @(negedge c7m);
    build_model(); run_scan("t5", cyc);

    // 6: board limit with three I/O cards
    nb = 3;
    set_board(0, 4'hD, 4'h1, 8'h05, 16'h1111);
    set_board(1, 4'hD, 4'h1, 8'h06, 16'h2222);
    set_board(2, 4'hD, 4'h1, 8'h07, 16'h3333);
    pulse_reset(); build_model(); run_scan("t6", cyc);
    chk("t6:base0", res[0], 9'h0E9);
    chk("t6:base1", res[1], 9'h0EA);
    chk("t6:third_untouched", touched[2], 0);

    // Random chains
    for (int r = 0; r < 10; r++) begin
      logic mem, rom;
      nb = $urandom_range(0, NSLOT);
      for (int i = 0; i < NSLOT; i++) begin
        mem = 1'($urandom_range(0, 1));
        rom = 1'($urandom_range(0, 1));
        if (mem && rom) rom = 1'b0;
        set_board(i, {2'b11, mem, rom}, 4'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
      end
      pulse_reset(); build_model(); run_scan($sformatf("rnd%0d", r), cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
